bcd_mod_counter: RTL and testbench

BCD_MOD_COUNTER -- requirements
Module: bcd_mod_counter

---
 rtl/bcd_mod_counter_pkg.sv | 37 +++
 rtl/bcd_digit_step.sv | 40 ++++
 rtl/bcd_mod_counter.sv | 113 +++++++++++
 tb/tb_bcd_mod_counter.sv | 209 ++++++++++++++++++++
 4 files changed

// File: rtl/bcd_mod_counter_pkg.sv
// ============================================================================
// Module   : bcd_mod_counter_pkg
// Purpose  : Shared BCD types, constant conversion and load validity check.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package bcd_mod_counter_pkg;

    typedef logic [3:0] bcd_digit_t;

    typedef enum logic {
        RUN  = 1'b0,
        HALT = 1'b1
    } ctrl_state_t;

    // Binary 0..99 to packed two-digit BCD, usable in constant expressions.
    function automatic logic [7:0] bin_to_bcd(input int unsigned v);
        bcd_digit_t tens;
        bcd_digit_t units;
        tens  = 4'((v / 10) % 10);
        units = 4'(v % 10);
        return {tens, units};
    endfunction

    function automatic logic bcd_valid(input logic [7:0] v, input int unsigned modulus);
        int unsigned value;
        if ((v[7:4] > 4'd9) || (v[3:0] > 4'd9)) begin
            return 1'b0;
        end
        value = 32'(v[7:4]) * 32'd10 + 32'(v[3:0]);
        return (value < modulus);
    endfunction

endpackage

`default_nettype wire

// File: rtl/bcd_digit_step.sv
// ============================================================================
// Module   : bcd_digit_step
// Purpose  : Combinational single BCD digit +/-1 with carry/borrow in and out.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module bcd_digit_step (
    input  logic [3:0] d,
    input  logic       up,
    input  logic       cin,
    output logic [3:0] q,
    output logic       cout
);

    always_comb begin
        q    = d;
        cout = 1'b0;
        if (cin) begin
            if (up) begin
                if (d >= 4'd9) begin
                    q    = 4'd0;
                    cout = 1'b1;
                end else begin
                    q = d + 4'd1;
                end
            end else begin
                if (d == 4'd0) begin
                    q    = 4'd9;
                    cout = 1'b1;
                end else begin
                    q = d - 4'd1;
                end
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/bcd_mod_counter.sv
// ============================================================================
// Module   : bcd_mod_counter
// Purpose  : Two-digit BCD up/down modulo counter with load, wrap/one-shot.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module bcd_mod_counter
    import bcd_mod_counter_pkg::*;
#(
    parameter int unsigned MOD     = 60,
    parameter int unsigned WRAP    = 1,
    parameter int unsigned RST_VAL = 0
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       ce,
    input  logic       up,
    input  logic       L,
    input  logic [7:0] DI,
    output logic [7:0] Q,
    output logic       CO,
    output logic       done,
    output logic       err
);

    localparam logic [7:0] C_MAX_BCD = bin_to_bcd(MOD - 1);
    localparam logic [7:0] C_RST_BCD = bin_to_bcd(RST_VAL);

    generate
        if ((MOD < 2) || (MOD > 100) || (RST_VAL >= MOD)) begin : g_param_check
            $error("bcd_mod_counter: MOD must be 2..100 and RST_VAL < MOD");
        end
    endgenerate

    logic [7:0]  q_q, q_d;
    ctrl_state_t state_q, state_d;
    logic        err_q, err_d;

    logic [7:0]  terminal;
    logic        at_term;
    logic        load_ok;
    logic [3:0]  units_nxt, tens_nxt;
    logic        units_cout;
    logic        tens_cout_unused;

    bcd_digit_step u_units (
        .d    (q_q[3:0]),
        .up   (up),
        .cin  (1'b1),
        .q    (units_nxt),
        .cout (units_cout)
    );

    // A tens carry/borrow only arises at the terminal value, which is handled
    // separately below, so the tens carry-out is never needed.
    bcd_digit_step u_tens (
        .d    (q_q[7:4]),
        .up   (up),
        .cin  (units_cout),
        .q    (tens_nxt),
        .cout (tens_cout_unused)
    );

    always_comb begin
        terminal = up ? C_MAX_BCD : 8'h00;
        at_term  = (q_q == terminal);
        load_ok  = bcd_valid(DI, MOD);
        CO       = ce & (state_q == RUN) & ~L & at_term;

        q_d     = q_q;
        state_d = state_q;
        err_d   = 1'b0;

        if (L) begin
            if (load_ok) begin
                q_d     = DI;
                state_d = RUN;
            end else begin
                err_d = 1'b1;
            end
        end else if (ce && (state_q == RUN)) begin
            if (at_term) begin
                if (WRAP != 0) begin
                    q_d = up ? 8'h00 : C_MAX_BCD;
                end else begin
                    state_d = HALT;
                end
            end else begin
                q_d = {tens_nxt, units_nxt};
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q_q     <= C_RST_BCD;
            state_q <= RUN;
            err_q   <= 1'b0;
        end else begin
            q_q     <= q_d;
            state_q <= state_d;
            err_q   <= err_d;
        end
    end

    assign Q    = q_q;
    assign done = (state_q == HALT);
    assign err  = err_q;

endmodule

`default_nettype wire

// File: tb/tb_bcd_mod_counter.sv
// ============================================================================
// Module   : tb_bcd_mod_counter
// Purpose  : Scoreboard bench for bcd_mod_counter across five parameter sets.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_bcd_mod_counter;

    localparam int N = 5;

    logic       clk = 1'b0;
    logic       rst;
    logic       ce_a   [N];
    logic       up_a   [N];
    logic       l_a    [N];
    logic [7:0] di_a   [N];
    logic [7:0] q_a    [N];
    logic       co_a   [N];
    logic       done_a [N];
    logic       err_a  [N];
    logic       co_s   [N];

    always #5 clk = ~clk;

    bcd_mod_counter #(.MOD(60), .WRAP(1), .RST_VAL(0)) u_dut0 (
        .clk(clk), .rst(rst), .ce(ce_a[0]), .up(up_a[0]), .L(l_a[0]), .DI(di_a[0]),
        .Q(q_a[0]), .CO(co_a[0]), .done(done_a[0]), .err(err_a[0]));
    bcd_mod_counter #(.MOD(24), .WRAP(1), .RST_VAL(0)) u_dut1 (
        .clk(clk), .rst(rst), .ce(ce_a[1]), .up(up_a[1]), .L(l_a[1]), .DI(di_a[1]),
        .Q(q_a[1]), .CO(co_a[1]), .done(done_a[1]), .err(err_a[1]));
    bcd_mod_counter #(.MOD(10), .WRAP(0), .RST_VAL(0)) u_dut2 (
        .clk(clk), .rst(rst), .ce(ce_a[2]), .up(up_a[2]), .L(l_a[2]), .DI(di_a[2]),
        .Q(q_a[2]), .CO(co_a[2]), .done(done_a[2]), .err(err_a[2]));
    bcd_mod_counter #(.MOD(60), .WRAP(1), .RST_VAL(30)) u_dut3 (
        .clk(clk), .rst(rst), .ce(ce_a[3]), .up(up_a[3]), .L(l_a[3]), .DI(di_a[3]),
        .Q(q_a[3]), .CO(co_a[3]), .done(done_a[3]), .err(err_a[3]));
    bcd_mod_counter #(.MOD(100), .WRAP(1), .RST_VAL(0)) u_dut4 (
        .clk(clk), .rst(rst), .ce(ce_a[4]), .up(up_a[4]), .L(l_a[4]), .DI(di_a[4]),
        .Q(q_a[4]), .CO(co_a[4]), .done(done_a[4]), .err(err_a[4]));

    typedef struct {
        int         inst;
        logic       co;
        logic [7:0] q;
        logic       done;
        logic       err;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    function automatic void check(input string name, input logic [7:0] act, input logic [7:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, req);
        end
    endfunction

    function automatic logic [7:0] bcd(input int v);
        logic [3:0] t;
        logic [3:0] u;
        t = 4'(v / 10);
        u = 4'(v % 10);
        return {t, u};
    endfunction

    // Drive one cycle of stimulus on instance k; CO is expected for this cycle,
    // Q/done/err for the state after the coming rising edge.
    task automatic step(input int k, input logic c, input logic u, input logic ld,
                        input logic [7:0] d, input logic eco, input logic [7:0] eq,
                        input logic edn, input logic eer);
        exp_t e;
        @(negedge clk);
        for (int i = 0; i < N; i++) begin
            ce_a[i] = 1'b0;
            l_a[i]  = 1'b0;
        end
        ce_a[k] = c;
        up_a[k] = u;
        l_a[k]  = ld;
        di_a[k] = d;
        e.inst = k;
        e.co   = eco;
        e.q    = eq;
        e.done = edn;
        e.err  = eer;
        sb.push_back(e);
    endtask

    // Monitor: CO sampled mid-cycle, registered outputs just after the edge.
    initial begin
        forever begin
            @(negedge clk);
            #1;
            for (int i = 0; i < N; i++) co_s[i] = co_a[i];
            @(posedge clk);
            #1;
            if (sb.size() > 0) begin
                exp_t e;
                e = sb.pop_front();
                check($sformatf("inst%0d CO", e.inst), {7'd0, co_s[e.inst]}, {7'd0, e.co});
                check($sformatf("inst%0d Q", e.inst), q_a[e.inst], e.q);
                check($sformatf("inst%0d done", e.inst), {7'd0, done_a[e.inst]}, {7'd0, e.done});
                check($sformatf("inst%0d err", e.inst), {7'd0, err_a[e.inst]}, {7'd0, e.err});
            end
        end
    end

    initial begin
        int guard;
        rst = 1'b1;
        for (int i = 0; i < N; i++) begin
            ce_a[i] = 1'b0;
            up_a[i] = 1'b1;
            l_a[i]  = 1'b0;
            di_a[i] = 8'h00;
        end

        // Reset values
        step(0, 0, 1, 0, 8'h00, 0, 8'h00, 0, 0);
        step(3, 0, 1, 0, 8'h00, 0, 8'h30, 0, 0);
        step(4, 0, 1, 0, 8'h00, 0, 8'h00, 0, 0);
        step(2, 0, 1, 0, 8'h00, 0, 8'h00, 0, 0);
        rst = 1'b0;

        // Full up-count with wrap, modulus 60
        for (int v = 0; v < 60; v++)
            step(0, 1, 1, 0, 8'h00, (v == 59), bcd((v + 1) % 60), 0, 0);

        // Rejected loads then an accepted boundary load
        step(0, 0, 1, 1, 8'h6A, 0, 8'h00, 0, 1);
        step(0, 0, 1, 0, 8'h00, 0, 8'h00, 0, 0);
        step(0, 0, 1, 1, 8'h60, 0, 8'h00, 0, 1);
        step(0, 0, 1, 0, 8'h00, 0, 8'h00, 0, 0);
        step(0, 0, 1, 1, 8'h59, 0, 8'h59, 0, 0);

        // Modulus-24 down-count with borrow and wrap, then immediate direction change
        step(1, 0, 0, 1, 8'h05, 0, 8'h05, 0, 0);
        step(1, 1, 0, 0, 8'h00, 0, 8'h04, 0, 0);
        step(1, 1, 0, 0, 8'h00, 0, 8'h03, 0, 0);
        step(1, 1, 0, 0, 8'h00, 0, 8'h02, 0, 0);
        step(1, 1, 0, 0, 8'h00, 0, 8'h01, 0, 0);
        step(1, 1, 0, 0, 8'h00, 0, 8'h00, 0, 0);
        step(1, 1, 0, 0, 8'h00, 1, 8'h23, 0, 0);
        step(1, 1, 1, 0, 8'h00, 1, 8'h00, 0, 0);

        // One-shot run, modulus 10
        step(2, 0, 1, 1, 8'h07, 0, 8'h07, 0, 0);
        step(2, 1, 1, 0, 8'h00, 0, 8'h08, 0, 0);
        step(2, 1, 1, 0, 8'h00, 0, 8'h09, 0, 0);
        step(2, 1, 1, 0, 8'h00, 1, 8'h09, 1, 0);
        step(2, 1, 1, 0, 8'h00, 0, 8'h09, 1, 0);
        step(2, 1, 0, 0, 8'h00, 0, 8'h09, 1, 0);
        step(2, 0, 1, 1, 8'h0A, 0, 8'h09, 1, 1);
        step(2, 1, 1, 1, 8'h03, 0, 8'h03, 0, 0);
        step(2, 1, 1, 0, 8'h00, 0, 8'h04, 0, 0);

        // Modulus-100 around 99/00 with direction toggling and load priority
        step(4, 0, 1, 1, 8'h98, 0, 8'h98, 0, 0);
        step(4, 1, 1, 0, 8'h00, 0, 8'h99, 0, 0);
        step(4, 1, 0, 0, 8'h00, 0, 8'h98, 0, 0);
        step(4, 1, 1, 0, 8'h00, 0, 8'h99, 0, 0);
        step(4, 1, 1, 0, 8'h00, 1, 8'h00, 0, 0);
        step(4, 1, 0, 0, 8'h00, 1, 8'h99, 0, 0);
        step(4, 1, 1, 1, 8'h00, 0, 8'h00, 0, 0);
        step(4, 1, 0, 0, 8'h00, 1, 8'h99, 0, 0);
        step(4, 0, 1, 0, 8'h00, 0, 8'h99, 0, 0);
        step(4, 1, 1, 1, 8'h9A, 0, 8'h99, 0, 1);
        step(4, 0, 1, 0, 8'h00, 0, 8'h99, 0, 0);

        // Asynchronous reset mid-count with RST_VAL=30
        step(3, 0, 1, 1, 8'h47, 0, 8'h47, 0, 0);
        @(posedge clk);
        #3 rst = 1'b1;
        #1;
        check("async rst Q", q_a[3], 8'h30);
        check("async rst done", {7'd0, done_a[3]}, 8'h00);
        @(negedge clk);
        for (int i = 0; i < N; i++) begin
            ce_a[i] = 1'b0;
            l_a[i]  = 1'b0;
        end
        rst = 1'b0;
        step(3, 1, 1, 0, 8'h00, 0, 8'h31, 0, 0);
        step(3, 1, 1, 0, 8'h00, 0, 8'h32, 0, 0);
        step(3, 0, 1, 0, 8'h00, 0, 8'h32, 0, 0);

        guard = 0;
        while ((sb.size() > 0) && (guard < 20)) begin
            @(posedge clk);
            guard++;
        end
        #3;
        if (sb.size() > 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL scoreboard drain: %0d entries left, expected 0", sb.size());
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
